// File: rtl/lif_spike_window_counter.sv
// lif_spike_window_counter: counts LIF spikes over programmable windows, one saturating result per window.
// Define LIF_ISI_EN to add isi_data, the gap between the last two spikes of each window.
module lif_spike_window_counter #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             spike_in,
    input  logic [WIN_W-1:0] win_len,
    output logic [CNT_W-1:0] cnt_data,
    output logic             cnt_sat,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic             drop_sticky,
    input  logic             clr_drop
`ifdef LIF_ISI_EN
    ,
    output logic [WIN_W-1:0] isi_data
`endif
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [WIN_W-1:0] win_lim;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] acc_nxt;
    logic             sat;
    logic             sat_nxt;
    logic             end_win;
    logic             accept;

    // sat marks a spike lost to saturation, so the count is no longer exact
    always_comb begin
        acc_nxt = (spike_in && acc != '1) ? acc + 1'b1 : acc;
        sat_nxt = sat || (spike_in && acc == '1);
        end_win = state == RUN && en && win_cnt == win_lim - 1'b1;
        accept  = !cnt_valid || cnt_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            win_lim <= '0;
            win_cnt <= '0;
            acc     <= '0;
            sat     <= 1'b0;
        end else if (state == IDLE || !en || end_win) begin
            state   <= (en && win_len != '0) ? RUN : IDLE;
            win_lim <= win_len;
            win_cnt <= '0;
            acc     <= '0;
            sat     <= 1'b0;
        end else begin
            win_cnt <= win_cnt + 1'b1;
            acc     <= acc_nxt;
            sat     <= sat_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_data    <= '0;
            cnt_sat     <= 1'b0;
            cnt_valid   <= 1'b0;
            drop_sticky <= 1'b0;
        end else begin
            if (end_win && accept) begin
                cnt_data  <= acc_nxt;
                cnt_sat   <= sat_nxt;
                cnt_valid <= 1'b1;
            end else if (cnt_ready) begin
                cnt_valid <= 1'b0;
            end
            drop_sticky <= (end_win && !accept) || (drop_sticky && !clr_drop);
        end
    end

`ifdef LIF_ISI_EN
    logic [WIN_W-1:0] isi_tmr;
    logic [WIN_W-1:0] isi_gap;
    logic             isi_have;
    logic             isi_two;
    logic             fin_two;
    logic [WIN_W-1:0] fin_gap;

    // a spike on the window's last cycle still contributes its gap
    always_comb begin
        fin_two = isi_two || (spike_in && isi_have);
        fin_gap = (spike_in && isi_have) ? isi_tmr : isi_gap;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || state != RUN || !en || end_win) begin
            isi_tmr  <= '0;
            isi_gap  <= '0;
            isi_have <= 1'b0;
            isi_two  <= 1'b0;
        end else begin
            isi_tmr <= spike_in ? WIN_W'(1) : (isi_tmr == '1 ? isi_tmr : isi_tmr + 1'b1);
            if (spike_in) begin
                isi_have <= 1'b1;
                if (isi_have) begin
                    isi_gap <= isi_tmr;
                    isi_two <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            isi_data <= '0;
        else if (end_win && accept)
            isi_data <= fin_two ? fin_gap : '0;
    end
`endif
endmodule
